// File: rtl/a51_keystream_cipher.sv
// a51_keystream_cipher: A5/1 keystream generator (R1/R2/R3, majority clocking, key/frame load, warm-up)
// XORed onto a valid/ready word stream; the same block encrypts and decrypts.
module a51_keystream_cipher #(
    parameter int DATA_W        = 8,
    parameter int KEY_W         = 64,
    parameter int FRAME_W       = 22,
    parameter int WARMUP_CYCLES = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [63:0]       secret_key,
    input  logic [21:0]       public_key,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_FRAME, WARMUP, RUN} state_t;

    state_t            state, state_next;
    logic [31:0]       step_cnt;
    logic [18:0]       r1, r1_next;
    logic [21:0]       r2, r2_next;
    logic [22:0]       r3, r3_next;
    logic [63:0]       key_sh;
    logic [21:0]       frame_sh;
    logic [DATA_W-1:0] acc, acc_next, ks_buf;
    logic [DATA_W:0]   acc_ext;
    logic [CW-1:0]     acc_cnt, cnt_next;
    logic              ks_valid, loading, load_bit, maj, s1, s2, s3, ks_bit;
    logic              accept, ks_free, acc_full, gen, word_done, last_step, step_en, load_buf;

    always_comb begin
        loading   = state == LOAD_KEY || state == LOAD_FRAME;
        busy      = loading || state == WARMUP;
        load_bit  = state == LOAD_KEY ? key_sh[0] : state == LOAD_FRAME ? frame_sh[0] : 1'b0;
        maj       = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        s1        = loading || r1[8] == maj;
        s2        = loading || r2[10] == maj;
        s3        = loading || r3[10] == maj;
        r1_next   = s1 ? {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ load_bit} : r1;
        r2_next   = s2 ? {r2[20:0], r2[21] ^ r2[20] ^ load_bit} : r2;
        r3_next   = s3 ? {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ load_bit} : r3;
        ks_bit    = r1_next[18] ^ r2_next[21] ^ r3_next[22];
        in_ready  = state == RUN && ks_valid && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        ks_free   = !ks_valid || accept;
        acc_full  = acc_cnt == CW'(DATA_W);
        // a full accumulator only blocks generation while ks_buf cannot take it
        gen       = state == RUN && (!acc_full || ks_free);
        step_en   = busy || gen;
        acc_ext   = {acc, ks_bit};
        acc_next  = acc_ext[DATA_W-1:0];
        cnt_next  = (acc_full ? CW'(0) : acc_cnt) + CW'(1);
        word_done = cnt_next == CW'(DATA_W);
        load_buf  = gen && ks_free && (acc_full || word_done);
        last_step = step_cnt == (state == LOAD_KEY   ? 32'(KEY_W - 1) :
                                 state == LOAD_FRAME ? 32'(FRAME_W - 1) : 32'(WARMUP_CYCLES - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_KEY:   state_next = last_step ? LOAD_FRAME : LOAD_KEY;
            LOAD_FRAME: state_next = !last_step ? LOAD_FRAME : WARMUP_CYCLES == 0 ? RUN : WARMUP;
            WARMUP:     state_next = last_step ? RUN : WARMUP;
            default:    state_next = state;
        endcase
        if (start) state_next = LOAD_KEY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            key_sh <= '0;
            frame_sh <= '0;
            step_cnt <= '0;
            acc <= '0;
            acc_cnt <= '0;
            ks_buf <= '0;
            ks_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
        end else if (start) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            key_sh <= secret_key;
            frame_sh <= public_key;
            step_cnt <= '0;
            acc <= '0;
            acc_cnt <= '0;
            ks_buf <= '0;
            ks_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
        end else begin
            if (step_en) begin
                r1 <= r1_next;
                r2 <= r2_next;
                r3 <= r3_next;
            end
            if (state == LOAD_KEY) key_sh <= key_sh >> 1;
            if (state == LOAD_FRAME) frame_sh <= frame_sh >> 1;
            step_cnt <= (busy && !last_step) ? step_cnt + 32'd1 : 32'd0;
            if (gen) begin
                acc <= acc_next;
                acc_cnt <= (load_buf && !acc_full) ? CW'(0) : cnt_next;
            end
            // a stalled full word takes priority; the bit generated alongside it starts the next word
            if (load_buf) ks_buf <= acc_full ? acc : acc_next;
            ks_valid <= load_buf || (ks_valid && !accept);
            if (accept) begin
                out_data <= in_data ^ ks_buf;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_a51_keystream_cipher.sv
// tb_a51_keystream_cipher: directed checks of an encrypting instance chained into a decrypting one,
// with an independent bit-serial A5/1 reference for the keystream.
module tb_a51_keystream_cipher;
    localparam logic [63:0] GOLD_KEY = 64'h1223456789ABCDEF;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, out2_ready;
    logic [63:0] skey;
    logic [21:0] fkey;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, busy, in_ready2, out_valid2, busy2;
    logic [7:0]  out_data, out_data2;

    int   checks = 0;
    int   failures = 0;
    bit   ks_exp[0:2047];
    logic [7:0] pt[0:255];

    always #5 clk = ~clk;

    a51_keystream_cipher dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(skey), .public_key(fkey),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(in_ready2), .out_data(out_data), .busy(busy)
    );

    a51_keystream_cipher dut2 (
        .clk(clk), .reset(reset), .start(start), .secret_key(skey), .public_key(fkey),
        .in_valid(out_valid), .in_ready(in_ready2), .in_data(out_data),
        .out_valid(out_valid2), .out_ready(out2_ready), .out_data(out_data2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference generator: parity-of-mask feedback, bit-serial key/frame load, then majority clocking.
    task automatic model(input logic [63:0] k, input logic [21:0] f, input int nbits);
        logic [18:0] a;
        logic [21:0] b;
        logic [22:0] c;
        logic        m, ib;
        a = '0;
        b = '0;
        c = '0;
        for (int i = 0; i < 86; i++) begin
            ib = (i < 64) ? k[0] : f[0];
            if (i < 64) k = k >> 1;
            else f = f >> 1;
            a = {a[17:0], ^(a & 19'h72000) ^ ib};
            b = {b[20:0], ^(b & 22'h300000) ^ ib};
            c = {c[21:0], ^(c & 23'h700080) ^ ib};
        end
        for (int i = 0; i < 100 + nbits; i++) begin
            m = (int'(a[8]) + int'(b[10]) + int'(c[10])) >= 2;
            if (a[8] == m) a = {a[17:0], ^(a & 19'h72000)};
            if (b[10] == m) b = {b[20:0], ^(b & 22'h300000)};
            if (c[10] == m) c = {c[21:0], ^(c & 23'h700080)};
            if (i >= 100) ks_exp[i-100] = a[18] ^ b[21] ^ c[22];
        end
    endtask

    function automatic logic [7:0] ks_word(input int w);
        logic [7:0] r = '0;
        for (int j = 0; j < 8; j++) r = {r[6:0], ks_exp[8*w+j]};
        return r;
    endfunction

    // start pulse, then busy must last 186 cycles and in_ready rise 194 edges after the start edge
    task automatic start_and_measure(input logic [63:0] k, input logic [21:0] f);
        int edges = 0;
        int busy_cnt;
        @(negedge clk);
        skey = k;
        fkey = f;
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_out_valid", out_valid, 0);
        check("start_out_valid2", out_valid2, 0);
        check("start_in_ready", in_ready, 0);
        busy_cnt = int'(busy);
        while (!in_ready && edges < 400) begin
            @(posedge clk);
            #1 edges++;
            busy_cnt += int'(busy);
        end
        check("first_word_latency", edges, 194);
        check("busy_cycles", busy_cnt, 186);
    endtask

    task automatic run_words(input int n, input bit bp);
        int p = 0, q = 0, r = 0, cyc = 0;
        bit st1 = 0, st2 = 0;
        logic [7:0] h1 = '0, h2 = '0;
        while (r < n && cyc < n * 64 + 200) begin
            @(negedge clk);
            cyc++;
            in_valid = p < n;
            in_data = (p < n) ? pt[p] : 8'h00;
            out2_ready = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
            #1;
            if (st1) check("hold_ct", {out_valid, out_data}, {1'b1, h1});
            if (st2) check("hold_pt", {out_valid2, out_data2}, {1'b1, h2});
            if (out_valid && in_ready2) begin
                check("ct_word", out_data, pt[q] ^ ks_word(q));
                q++;
            end
            if (out_valid2 && out2_ready) begin
                check("pt_word", out_data2, pt[r]);
                r++;
            end
            if (in_valid && in_ready) p++;
            st1 = out_valid && !in_ready2;
            h1 = out_data;
            st2 = out_valid2 && !out2_ready;
            h2 = out_data2;
        end
        check("words_done", r, n);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out2_ready = 1'b1;
        skey = '0;
        fkey = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("idle_busy", busy, 0);

        // all-zero key and frame: keystream is zero, so ciphertext equals plaintext
        start_and_measure(64'h0, 22'h0);
        model(64'h0, 22'h0, 2048);
        for (int i = 0; i < 256; i++) pt[i] = 8'(i);
        run_words(256, 1'b0);

        // golden key/frame, zero plaintext exposes the raw keystream (232 >= 228 bits)
        start_and_measure(GOLD_KEY, 22'h134);
        model(GOLD_KEY, 22'h134, 320);
        for (int i = 0; i < 256; i++) pt[i] = 8'h00;
        run_words(29, 1'b0);

        // backpressure on the sink, random plaintext, round trip through the second instance
        start_and_measure(GOLD_KEY, 22'h134);
        for (int i = 0; i < 256; i++) pt[i] = 8'($urandom);
        run_words(40, 1'b1);

        // back up the pipeline so a result word is pending, then rekey to frame 0x135
        @(negedge clk);
        in_valid = 1'b1;
        out2_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("pending_before_rekey", out_valid, 1);
        start_and_measure(GOLD_KEY, 22'h135);
        model(GOLD_KEY, 22'h135, 320);
        for (int i = 0; i < 256; i++) pt[i] = 8'($urandom);
        run_words(12, 1'b0);

        // asynchronous reset in the middle of warm-up
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (120) @(posedge clk);
        #1 check("warmup_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_in_ready", in_ready, 0);
        check("async_out_valid", out_valid, 0);
        @(negedge clk) reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_in_ready", in_ready, 0);
        check("post_rst_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/a51_keystream_cipher.md
Name: a51_keystream_cipher

Overview:
- Parametrised successor to the team's A5/1 top: the three LFSRs (R1/R2/R3) with majority clocking, plus a full key/frame load sequencer and a configurable warm-up.
- Packs keystream bits into DATA_W-bit words and XORs them onto a valid/ready pixel stream.
- Sits between the image source and the encrypted-image sink; the same block decrypts.

Parameters:
DATA_W, 8, data word width; DATA_W keystream bits per word
KEY_W, 64, secret-key bits loaded (1..64)
FRAME_W, 22, public-key (frame) bits loaded (1..22)
WARMUP_CYCLES, 100, majority-clocked steps discarded before keystream output

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  pulse; samples keys and begins (re)keying from any state
secret_key  in  64  key; bit i loaded at load step i (LSB first)
public_key  in  22  frame number; bit i loaded at frame step i
in_valid  in  1  plaintext word valid
in_ready  out  1  plaintext word accepted when in_valid&&in_ready
in_data  in  DATA_W  plaintext/ciphertext word
out_valid  out  1  result word valid
out_ready  in  1  sink accepts
out_data  out  DATA_W  in_data XOR keystream word
busy  out  1  high in LOAD_KEY, LOAD_FRAME and WARMUP

Behaviour:
- Reset values:
  - R1/R2/R3, accumulator, ks_buf, output register and counters all 0.
  - State IDLE; in_ready, out_valid and busy 0; out_data 0.
- LFSRs:
  - R1 is 19 bits, taps 18,17,16,13, clocking bit 8.
  - R2 is 22 bits, taps 21,20, clocking bit 10.
  - R3 is 23 bits, taps 22,21,20,7, clocking bit 10.
  - Shift toward the MSB; the XOR of the taps enters bit 0.
  - Majority maj = majority of the three clocking bits; a register steps only when its clocking bit equals maj.
- State IDLE: waits for start.
  - start (sampled on the edge) zeroes R1/R2/R3, latches the keys and flushes the accumulator, ks_buf and output register. Next state is LOAD_KEY.
- State LOAD_KEY: KEY_W cycles.
  - All three registers step unconditionally.
  - The latched key bit i is XORed into bit 0 after feedback.
- State LOAD_FRAME: FRAME_W cycles, same as LOAD_KEY using frame bit i.
- State WARMUP: WARMUP_CYCLES majority-clocked steps, output discarded.
  - If WARMUP_CYCLES = 0, go straight to RUN.
- State RUN:
  - Each generation cycle performs one majority step.
  - The keystream bit is R1[18]^R2[21]^R3[22] of the post-step state.
  - Bit j of a word (j = 0 first) goes to word bit DATA_W-1-j.
- Word buffering:
  - A full accumulator moves to ks_buf on the same edge as its last bit if ks_buf is empty.
  - Generation stalls, with the registers frozen, while the accumulator is full and ks_buf is occupied.
  - No keystream bit is ever dropped or repeated.
- Latency: ks_buf becomes valid KEY_W+FRAME_W+WARMUP_CYCLES+DATA_W edges after the start edge (194 with defaults).
- Handshake:
  - in_ready = RUN && ks_valid && (!out_valid || out_ready).
  - On accept, out_data <= in_data ^ ks_buf and out_valid <= 1 on the next edge, and ks_buf is consumed.
  - out_valid clears on out_ready without a new accept.
  - out_data is held stable while out_valid && !out_ready.
  - One word per cycle is sustained when DATA_W = 1; otherwise throughput is 1 word per DATA_W cycles.
- start in any non-IDLE state restarts at LOAD_KEY next edge:
  - pending out_valid and ks_buf are discarded;
  - in_ready is 0 from the same edge;
  - keys are re-sampled.
- Reset mid-operation returns to IDLE immediately (asynchronous); no partial state survives.
- Keystream with an all-zero key and frame is all-zero: every register stays 0.

Test Plan:
- Reset → zero values: assert reset mid-WARMUP → busy, in_ready and out_valid drop to 0 asynchronously; after release the block stays in IDLE until start.
- Zero key (identity case): secret_key=0, public_key=0, start, feed in_data 0x00..0xFF with out_ready=1 → out_data equals in_data for all 256 words.
- First-word latency: start with default parameters → busy high 186 cycles, in_ready first high 194 edges after the start edge.
- Golden vector: secret_key=64'h1223456789ABCDEF, public_key=22'h134 → first 228 keystream bits (in_data=0) match the team golden C model bit-for-bit.
- Backpressure and round trip: same keys, out_ready toggled randomly (~30% low) → out_data held stable while stalled, no keystream word lost or repeated. A second instance with the same keys on the output recovers the original plaintext exactly.
- Rekey mid-stream: in RUN after 10 words, pulse start with public_key=22'h135 → out_valid drops next edge, 194-cycle gap, then output matches the golden model for frame 0x135 from bit 0.
